// File: rtl/messenger_pkg.sv
// Shared types and helpers for the messenger request queue.
// Pure declarations: no logic, no latency, no flow control.
package messenger_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

  typedef enum logic {IDLE, HOLD} out_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Register-based per-channel message FIFO; head visible combinationally, count/full registered.
// Push while full is ignored (caller reports overflow); flush empties it and beats push/pop.
module msg_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & (count != '0) & ~flush;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/messenger_queue.sv
// N-channel message request queue with a single presented output (grant registered: push->OUT_VLD in 2 cycles).
// Per-channel IN_RDY from FIFO fill; output held until OUT_POP or a flush of the presented channel.
module messenger_queue
  import messenger_pkg::*;
#(
  parameter int        NCH   = 6,
  parameter int        W     = 64,
  parameter int        DEPTH = 4,
  parameter arb_mode_t MODE  = ARB_FIXED
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NCH-1:0]              IN_VLD,
  input  logic [NCH*W-1:0]            IN_DATA,
  output logic [NCH-1:0]              IN_RDY,
  input  logic [NCH-1:0]              MASK,
  input  logic [NCH-1:0]              FLUSH,
  output logic                        OUT_VLD,
  output logic [clog2_min1(NCH)-1:0]  OUT_CH,
  output logic [W-1:0]                OUT_DATA,
  input  logic                        OUT_POP,
  output logic [NCH-1:0]              PEND,
  output logic [NCH-1:0]              OVF,
  input  logic [NCH-1:0]              OVF_CLR
);

  localparam int CW = clog2_min1(NCH);
  localparam int NW = $clog2(DEPTH) + 1;

  logic [NW-1:0]  cnt  [NCH];
  logic [W-1:0]   head [NCH];
  logic [NCH-1:0] full;
  logic [NCH-1:0] push_v;
  logic [NCH-1:0] pop_v;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] ovf_q;

  out_state_t     state, state_nxt;
  logic [CW-1:0]  out_ch_q;
  logic [W-1:0]   out_data_q;
  logic [CW-1:0]  rr_ptr;
  logic           grant_vld;
  logic [CW-1:0]  grant_ch;

  assign IN_RDY = ~full;
  assign push_v = IN_VLD & IN_RDY;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    msg_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (push_v[g]),
      .pop   (pop_v[g]),
      .flush (FLUSH[g]),
      .din   (IN_DATA[g*W +: W]),
      .dout  (head[g]),
      .count (cnt[g]),
      .full  (full[g])
    );
    assign pend[g] = (cnt[g] != '0);
  end

  // Clear wins over a same-cycle overflow set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ovf_q <= '0;
    else       ovf_q <= (ovf_q | (IN_VLD & ~IN_RDY)) & ~OVF_CLR;
  end

  always_comb begin
    pop_v = '0;
    if (state == HOLD && OUT_POP) pop_v[out_ch_q] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      out_ch_q   <= '0;
      out_data_q <= '0;
      rr_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_vld) begin
        out_ch_q   <= grant_ch;
        out_data_q <= head[grant_ch];
      end
      // A flush of the presented channel leaves the pointer where it was.
      if (MODE == ARB_RR && state == HOLD && OUT_POP && !FLUSH[out_ch_q])
        rr_ptr <= (out_ch_q == CW'(NCH-1)) ? '0 : out_ch_q + CW'(1);
    end
  end

  always_comb begin
    logic [NCH-1:0] elig;
    logic [CW-1:0]  idx;
    state_nxt = state;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    // A channel being flushed this cycle must not be presented from stale contents.
    elig      = pend & ~MASK & ~FLUSH;
    case (state)
      IDLE: begin
        for (int k = 0; k < NCH; k++) begin
          idx = (MODE == ARB_RR) ? CW'((int'(rr_ptr) + k) % NCH) : CW'(k);
          if (!grant_vld && elig[idx]) begin
            grant_vld = 1'b1;
            grant_ch  = idx;
          end
        end
        if (grant_vld) state_nxt = HOLD;
      end
      HOLD: begin
        if (FLUSH[out_ch_q] || OUT_POP) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    OUT_VLD  = (state == HOLD);
    OUT_CH   = out_ch_q;
    OUT_DATA = out_data_q;
    PEND     = pend;
    OVF      = ovf_q;
  end

endmodule
